// File: rtl/axi_lite_master.sv
// AXI-lite master: turns one command at a time into an AXI-lite write or read,
// watches every handshake with a timeout, and returns a single response.
module axi_lite_master #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clk,
  input  logic                rst,
  // command side
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  // response side
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_timeout,
  // AXI-lite write address / data / response
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  // AXI-lite read address / data
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    RADDR,
    RDATA,
    RESP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  r_awDone;
  logic                  r_wDone;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_W-1:0]     r_rspRdata;
  logic [1:0]            r_rspResp;
  logic                  r_rspTimeout;

  logic                  w_accept;
  logic                  w_awHs;
  logic                  w_wHs;
  logic                  w_busy;
  logic                  w_done;
  logic                  w_timeout;

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic, including the timeout escape from every AXI wait state
  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = cmd_wr ? WRITE : RADDR;
        end
      end
      WRITE: begin
        w_done = (r_awDone || w_awHs) && (r_wDone || w_wHs);
        if (w_done) begin
          w_next = WRESP;
        end
      end
      WRESP: begin
        w_done = bvalid;
        if (w_done) begin
          w_next = RESP;
        end
      end
      RADDR: begin
        w_done = arready;
        if (w_done) begin
          w_next = RDATA;
        end
      end
      RDATA: begin
        w_done = rvalid;
        if (w_done) begin
          w_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
    w_timeout = w_busy && !w_done && (r_count == CNT_LAST);
    if (w_timeout) begin
      w_next = RESP;
    end
  end

  // Output decode: valids/readies come straight from state and per-channel done flags
  always_comb begin
    w_busy      = (r_state == WRITE) || (r_state == WRESP) ||
                  (r_state == RADDR) || (r_state == RDATA);
    cmd_ready   = (r_state == IDLE) && !rst;
    w_accept    = cmd_valid && cmd_ready;
    awvalid     = (r_state == WRITE) && !r_awDone;
    wvalid      = (r_state == WRITE) && !r_wDone;
    bready      = (r_state == WRESP);
    arvalid     = (r_state == RADDR);
    rready      = (r_state == RDATA);
    rsp_valid   = (r_state == RESP);
    w_awHs      = awvalid && awready;
    w_wHs       = wvalid && wready;
    awaddr      = r_addr;
    araddr      = r_addr;
    wdata       = r_wdata;
    wstrb       = r_wstrb;
    rsp_rdata   = r_rspRdata;
    rsp_resp    = r_rspResp;
    rsp_timeout = r_rspTimeout;
  end

  // Datapath: command capture, handshake tracking, timeout counter, response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awDone     <= 1'b0;
      r_wDone      <= 1'b0;
      r_count      <= '0;
      r_rspRdata   <= '0;
      r_rspResp    <= 2'b00;
      r_rspTimeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= cmd_addr;
        r_wdata  <= cmd_wdata;
        r_wstrb  <= cmd_wstrb;
        r_awDone <= 1'b0;
        r_wDone  <= 1'b0;
      end
      if (w_awHs) begin
        r_awDone <= 1'b1;
      end
      if (w_wHs) begin
        r_wDone <= 1'b1;
      end
      if (w_busy && (w_next == r_state)) begin
        r_count <= r_count + CNT_W'(1);
      end else begin
        r_count <= '0;
      end
      if (w_timeout) begin
        r_rspRdata   <= '0;
        r_rspResp    <= 2'b10;
        r_rspTimeout <= 1'b1;
      end else if ((r_state == WRESP) && bvalid) begin
        r_rspRdata   <= '0;
        r_rspResp    <= bresp;
        r_rspTimeout <= 1'b0;
      end else if ((r_state == RDATA) && rvalid) begin
        r_rspRdata   <= rdata;
        r_rspResp    <= rresp;
        r_rspTimeout <= 1'b0;
      end else if ((r_state == RESP) && rsp_ready) begin
        r_rspRdata   <= '0;
        r_rspResp    <= 2'b00;
        r_rspTimeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Testbench for axi_lite_master: delay-programmable AXI-lite slave, directed
// vector table, multi-cycle reset/late-response sequences and random traffic.
module tb_axi_lite_master;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int TIMEOUT  = 8;
  localparam int MAX_WAIT = 60;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_wr;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic                rsp_timeout;
  logic                awvalid;
  logic                awready;
  logic [ADDR_W-1:0]   awaddr;
  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                bvalid;
  logic                bready;
  logic [1:0]          bresp;
  logic                arvalid;
  logic                arready;
  logic [ADDR_W-1:0]   araddr;
  logic                rvalid;
  logic                rready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;

  int assertCount = 0;
  int failCount   = 0;

  // slave behaviour knobs, set per transaction
  int          dAw, dW, dB, dAr, dR;
  logic [1:0]  sBresp, sRresp;
  logic [31:0] sRdata;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dAw, dW, dB, dAr, dR;
    logic [1:0]  sBresp, sRresp;
    logic [31:0] sRdata;
    int          hold;
    int          expLat;
    logic [1:0]  expResp;
    logic [31:0] expRdata;
    bit          expTo;
    int          expAw, expW, expAr;
  } vec_t;

  vec_t tbl[9];

  axi_lite_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  // free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(bit wr, logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                                 int aw, int w, int b, int ar, int r,
                                 logic [1:0] sb, logic [1:0] sr, logic [31:0] srd, int hold);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
    v.dAw = aw; v.dW = w; v.dB = b; v.dAr = ar; v.dR = r;
    v.sBresp = sb; v.sRresp = sr; v.sRdata = srd; v.hold = hold;
    v.expLat = 0; v.expResp = 2'b00; v.expRdata = '0; v.expTo = 0;
    v.expAw = 0; v.expW = 0; v.expAr = 0;
    return v;
  endfunction

  function automatic vec_t withExp(vec_t v, int lat, logic [1:0] resp, logic [31:0] rd, bit to,
                                   int aw, int w, int ar);
    vec_t r = v;
    r.expLat = lat; r.expResp = resp; r.expRdata = rd; r.expTo = to;
    r.expAw = aw; r.expW = w; r.expAr = ar;
    return r;
  endfunction

  function automatic int minInt(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Reference model: cycle of first rsp_valid (acceptance cycle = 0) and the
  // response contents, from the slave delays and the handshake/timeout rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int   phase2;
    r.expTo = 0; r.expAw = 0; r.expW = 0; r.expAr = 0;
    if (v.wr) begin
      r.expResp  = v.sBresp;
      r.expRdata = '0;
      r.expAw    = minInt(v.dAw + 1, TIMEOUT);
      r.expW     = minInt(v.dW + 1, TIMEOUT);
      if (v.dAw >= TIMEOUT || v.dW >= TIMEOUT) begin
        r.expLat = 1 + TIMEOUT;
        r.expTo  = 1;
      end else begin
        phase2 = 2 + ((v.dAw > v.dW) ? v.dAw : v.dW);
        if (v.dB >= TIMEOUT) begin
          r.expLat = phase2 + TIMEOUT;
          r.expTo  = 1;
        end else begin
          r.expLat = phase2 + v.dB + 1;
        end
      end
    end else begin
      r.expResp  = v.sRresp;
      r.expRdata = v.sRdata;
      r.expAr    = minInt(v.dAr + 1, TIMEOUT);
      if (v.dAr >= TIMEOUT) begin
        r.expLat = 1 + TIMEOUT;
        r.expTo  = 1;
      end else begin
        phase2 = 2 + v.dAr;
        if (v.dR >= TIMEOUT) begin
          r.expLat = phase2 + TIMEOUT;
          r.expTo  = 1;
        end else begin
          r.expLat = phase2 + v.dR + 1;
        end
      end
    end
    if (r.expTo) begin
      r.expResp  = 2'b10;
      r.expRdata = '0;
    end
    return r;
  endfunction

  // AXI-lite slave: readies after a programmable number of valid cycles,
  // responses a programmable number of cycles after the address/data phase
  initial begin
    int awCnt = 0, wCnt = 0, arCnt = 0, bCnt = 0, rCnt = 0;
    bit gotAw = 0, gotW = 0, bPend = 0, rPend = 0;
    bit hsAw, hsW, hsB, hsAr, hsR;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      hsAw = awvalid && awready;
      hsW  = wvalid && wready;
      hsB  = bvalid && bready;
      hsAr = arvalid && arready;
      hsR  = rvalid && rready;
      @(posedge clk);
      #1;
      if (rst) begin
        awCnt = 0; wCnt = 0; arCnt = 0; bCnt = 0; rCnt = 0;
        gotAw = 0; gotW = 0; bPend = 0; rPend = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      end else begin
        if (hsAw) gotAw = 1;
        if (hsW) gotW = 1;
        if (hsB) bPend = 0;
        if (hsR) rPend = 0;
        if (gotAw && gotW) begin
          bPend = 1; bCnt = 0; gotAw = 0; gotW = 0;
        end
        if (hsAr) begin
          rPend = 1; rCnt = 0;
        end
        if (awvalid) begin awready = (awCnt >= dAw); awCnt++; end
        else begin awready = 0; awCnt = 0; end
        if (wvalid) begin wready = (wCnt >= dW); wCnt++; end
        else begin wready = 0; wCnt = 0; end
        if (arvalid) begin arready = (arCnt >= dAr); arCnt++; end
        else begin arready = 0; arCnt = 0; end
        bvalid = bPend && (bCnt >= dB);
        if (bPend) bCnt++;
        rvalid = rPend && (rCnt >= dR);
        if (rPend) rCnt++;
      end
      bresp = sBresp;
      rresp = sRresp;
      rdata = sRdata;
    end
  end

  task automatic resetDut();
    @(posedge clk);
    #1;
    rst = 1; cmd_valid = 0; rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Issue one command, follow it to its response, hold rsp_ready low for v.hold cycles
  task automatic applyStimulus(input vec_t v, input string tag);
    int k = 1;
    bit seen = 0;
    int awHigh = 0, wHigh = 0, arHigh = 0, payloadErr = 0, busyReady = 0, holdErr = 0;
    logic [31:0] hRdata;
    logic [1:0]  hResp;
    logic        hTo;
    dAw = v.dAw; dW = v.dW; dB = v.dB; dAr = v.dAr; dR = v.dR;
    sBresp = v.sBresp; sRresp = v.sRresp; sRdata = v.sRdata;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.data; cmd_wstrb = v.strb;
    rsp_ready = 0;
    @(negedge clk);
    checkOutput({tag, ".cmdReady"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 0; cmd_wr = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_wstrb = 4'($urandom);
    while (!seen && k <= MAX_WAIT) begin
      @(negedge clk);
      if (awvalid) begin awHigh++; if (awaddr !== v.addr) payloadErr++; end
      if (wvalid) begin wHigh++; if (wdata !== v.data || wstrb !== v.strb) payloadErr++; end
      if (arvalid) begin arHigh++; if (araddr !== v.addr) payloadErr++; end
      if (cmd_ready) busyReady++;
      if (rsp_valid) seen = 1;
      else begin
        @(posedge clk);
        k++;
      end
    end
    if (!seen) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s.noResponse: no rsp_valid within %0d cycles, required at cycle %0d",
               tag, MAX_WAIT, v.expLat);
      resetDut();
      return;
    end
    checkOutput({tag, ".latency"}, k, v.expLat);
    checkOutput({tag, ".resp"}, rsp_resp, v.expResp);
    checkOutput({tag, ".rdata"}, rsp_rdata, v.expRdata);
    checkOutput({tag, ".timeoutFlag"}, rsp_timeout, v.expTo);
    checkOutput({tag, ".awCycles"}, awHigh, v.expAw);
    checkOutput({tag, ".wCycles"}, wHigh, v.expW);
    checkOutput({tag, ".arCycles"}, arHigh, v.expAr);
    checkOutput({tag, ".payloadStable"}, payloadErr, 0);
    checkOutput({tag, ".cmdReadyBusy"}, busyReady, 0);
    checkOutput({tag, ".axiQuietInResp"}, {awvalid, wvalid, arvalid, bready, rready}, 0);
    hRdata = rsp_rdata; hResp = rsp_resp; hTo = rsp_timeout;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== hRdata || rsp_resp !== hResp || rsp_timeout !== hTo || cmd_ready)
        holdErr++;
    end
    if (v.hold > 0) checkOutput({tag, ".holdStable"}, holdErr, 0);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    @(negedge clk);
    checkOutput({tag, ".afterResp"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    vec_t v;
    int   quietErr, lateErr, lateSeen;
    rst = 1; cmd_valid = 0; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    dAw = 0; dW = 0; dB = 0; dAr = 0; dR = 0; sBresp = 0; sRresp = 0; sRdata = 0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ctrl", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp,
                               awvalid, wvalid, bready, arvalid, rready}, 0);
    checkOutput("reset.rdata", rsp_rdata, 0);
    checkOutput("reset.addr", {awaddr, araddr}, 0);
    checkOutput("reset.wdata", {wdata, wstrb}, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checkOutput("reset.readyAfter", cmd_ready, 1);

    // directed vector table
    tbl[0] = withExp(mkVec(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0),
                     3, 2'b00, 32'h0, 0, 1, 1, 0);
    tbl[1] = withExp(mkVec(1, 32'h44, 32'hA5A50F0F, 4'h3, 4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0, 0),
                     7, 2'b00, 32'h0, 0, 5, 1, 0);
    tbl[2] = withExp(mkVec(0, 32'h20, 32'h0, 4'h0, 0, 0, 0, 0, 3, 2'b00, 2'b00, 32'h12345678, 0),
                     6, 2'b00, 32'h12345678, 0, 0, 0, 1);
    tbl[3] = withExp(mkVec(0, 32'h30, 32'h0, 4'h0, 0, 0, 0, 99, 0, 2'b00, 2'b00, 32'hCAFEF00D, 1),
                     9, 2'b10, 32'h0, 1, 0, 0, 8);
    tbl[4] = withExp(mkVec(0, 32'h34, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0BADC0DE, 5),
                     3, 2'b00, 32'h0BADC0DE, 0, 0, 0, 1);
    tbl[5] = withExp(mkVec(1, 32'h80, 32'h11223344, 4'h5, 1, 3, 2, 0, 0, 2'b01, 2'b00, 32'h0, 0),
                     8, 2'b01, 32'h0, 0, 2, 4, 0);
    tbl[6] = withExp(mkVec(0, 32'h90, 32'h0, 4'h0, 0, 0, 0, 2, 0, 2'b00, 2'b11, 32'hFFFF0000, 2),
                     5, 2'b11, 32'hFFFF0000, 0, 0, 0, 3);
    tbl[7] = withExp(mkVec(1, 32'hA0, 32'h01020304, 4'h8, 0, 0, 7, 0, 0, 2'b10, 2'b00, 32'h0, 0),
                     10, 2'b10, 32'h0, 0, 1, 1, 0);
    tbl[8] = withExp(mkVec(0, 32'hB0, 32'h0, 4'h0, 0, 0, 0, 7, 0, 2'b00, 2'b00, 32'h5A5A5A5A, 0),
                     10, 2'b00, 32'h5A5A5A5A, 0, 0, 0, 8);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end

    // reset while waiting for the write response
    dAw = 0; dW = 0; dB = 5; sBresp = 2'b00;
    @(posedge clk);
    #1;
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'hD0; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midRst.inWresp", bready, 1);
    @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midRst.outputs", {cmd_ready, rsp_valid, rsp_timeout, rsp_resp,
                                   awvalid, wvalid, bready, arvalid, rready}, 0);
    checkOutput("midRst.addr", awaddr, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    checkOutput("midRst.readyAfter", cmd_ready, 1);
    quietErr = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid || !cmd_ready) quietErr++;
    end
    checkOutput("midRst.noResponse", quietErr, 0);
    applyStimulus(model(mkVec(1, 32'hD4, 32'h0F0F0F0F, 4'hF, 0, 0, 0, 0, 0, 2'b01, 2'b00, 32'h0, 0)),
                  "midRst.next");

    // write response that arrives after the timeout must be ignored
    applyStimulus(model(mkVec(1, 32'hC0, 32'h77777777, 4'hF, 0, 0, 12, 0, 0, 2'b00, 2'b00, 32'h0, 0)),
                  "lateB");
    lateErr = 0;
    lateSeen = 0;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      if (bvalid) lateSeen++;
      if (bready || rsp_valid) lateErr++;
    end
    checkOutput("lateB.ignored", lateErr, 0);
    checkOutput("lateB.slaveResponded", lateSeen > 0, 1);
    resetDut();

    // random traffic against the reference model
    for (int i = 0; i < 40; i++) begin
      v = mkVec($urandom_range(0, 1), $urandom, $urandom, 4'($urandom),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 10) : $urandom_range(0, 3),
                2'($urandom), 2'($urandom), $urandom, $urandom_range(0, 3));
      v = model(v);
      applyStimulus(v, $sformatf("rnd%0d", i));
      if (v.expTo) resetDut();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
